uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Byte-stream command deframer sitting directly downstream of the UART receiver in the debug-transport path. Consumes one received byte per RX done pulse, synchronises on a header byte, assembles a read or write command (address plus optional 32-bit little-endian payload) and presents it on a valid/ready handshake to the debug-module-interface side. Malformed, stalled or overrunning frames are discarded and flagged.

## Interface
- CLK_RATE, 100000000, clock frequency in Hz
- BAUD_RATE, 115200, UART baud rate
- TIMEOUT_BYTES, 4, inter-byte gap limit in byte times (one byte time = 10 × (CLK_RATE/BAUD_RATE) cycles)
- HEADER, 8'h01, sync byte that opens every frame
- CLK_I  in  1  clock; one clock domain
- RST_I  in  1  synchronous, active-high reset
- RX_DONE_I  in  1  one-cycle strobe: RX_DATA_I holds a valid byte
- RX_DATA_I  in  8  received byte
- CMD_VALID_O  out  1  assembled command available
- CMD_READY_I  in  1  consumer accepts command when high together with CMD_VALID_O
- CMD_WRITE_O  out  1  1 = write, 0 = read
- CMD_ADDR_O  out  8  register address
- CMD_DATA_O  out  32  write payload; 0 for reads
- ERR_O  out  1  one-cycle error strobe
- ERR_CODE_O  out  2  01 bad command, 10 timeout, 11 overrun; holds last code until next ERR_O

## Operation
- Frame: HEADER, CMD, ADDR, then 4 data bytes (LSB first) only if CMD = 8'h02 (write). CMD = 8'h01 is read. Any other CMD value is a bad command.
- States: IDLE, GET_CMD, GET_ADDR, GET_DATA, HOLD.
- IDLE: byte == HEADER -> GET_CMD; any other byte silently ignored.
- GET_CMD: 01/02 -> latch write flag, GET_ADDR; else ERR_O, code 01, -> IDLE.
- GET_ADDR: latch address; read -> HOLD; write -> clear data reg, byte index 0, GET_DATA.
- GET_DATA: byte k written to CMD_DATA_O[8k+7:8k]; 2-bit index; after k = 3 -> HOLD.
- HOLD: CMD_VALID_O high; outputs stable. VALID & READY -> IDLE.
- Byte arriving in HOLD without same-cycle handshake: dropped, ERR_O, code 11, state unchanged.
- Byte arriving in HOLD on the handshake cycle: not an overrun; evaluated as in IDLE (HEADER -> GET_CMD).
- Timeout: counter of width $clog2(limit)+1 cleared on every accepted byte and on entry to GET_CMD; counts only in GET_CMD/GET_ADDR/GET_DATA; reaching limit -> IDLE, ERR_O, code 10, partial frame discarded. No timeout in IDLE or HOLD.
- HEADER value inside CMD/ADDR/DATA positions is plain data; no resync mid-frame.

## Timing
- Reset (RST_I high on a clock edge): state IDLE, CMD_VALID_O 0, CMD_WRITE_O 0, CMD_ADDR_O 0, CMD_DATA_O 0, ERR_O 0, ERR_CODE_O 00, counters 0. Reset mid-frame or in HOLD discards everything; no error reported.
- Bytes are sampled on the edge where RX_DONE_I is high; state advances that edge.
- CMD_VALID_O rises the cycle after the edge sampling the final byte (ADDR for read, data byte 3 for write): latency 1 cycle.
- CMD_VALID_O falls the cycle after the VALID & READY edge; back-to-back frames supported with no extra idle cycle.
- CMD_READY_I is ignored when CMD_VALID_O is low.
- ERR_O is high exactly one cycle, the cycle after the offending event; ERR_CODE_O updates in the same cycle.
- Timeout fires when counter equals TIMEOUT_BYTES × 10 × (CLK_RATE/BAUD_RATE) cycles after last byte; a byte arriving on that same edge wins (accepted, no timeout).
- RX_DONE_I assumed at most one cycle wide per byte; consecutive strobes on adjacent cycles are each processed.

## Test plan
- Read: bytes 01,01,3C with READY high -> CMD_VALID_O 1 cycle after 3C, WRITE 0, ADDR 3C, DATA 0; VALID drops next cycle.
- Write with backpressure: 01,02,10,EF,BE,AD,DE, READY low 20 cycles -> VALID held, ADDR 10, DATA DEADBEEF stable; READY high -> VALID low next cycle.
- Bad command and junk: 55,AA,01,07 -> no VALID; single ERR_O with code 01; following 01,01,05 decodes read of 05.
- Timeout: 01,02,20,11 then silence for limit cycles -> ERR_O code 10, IDLE; next full read frame decodes correctly.
- Overrun: complete read, READY low, send 01 -> ERR_O code 11, held command unchanged; byte coincident with handshake (01) -> no error, new frame starts.
- Reset in GET_DATA after 2 payload bytes -> all outputs 0, no ERR_O; fresh write frame decodes correctly.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: deframes HEADER/CMD/ADDR[/DATA x4] byte streams from the
// UART receiver into read/write commands on a valid/ready handshake.
module uart_cmd_decoder #(
  parameter int unsigned CLK_RATE      = 100000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter logic [7:0]  HEADER        = 8'h01
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        RX_DONE_I,
  input  logic [7:0]  RX_DATA_I,
  output logic        CMD_VALID_O,
  input  logic        CMD_READY_I,
  output logic        CMD_WRITE_O,
  output logic [7:0]  CMD_ADDR_O,
  output logic [31:0] CMD_DATA_O,
  output logic        ERR_O,
  output logic [1:0]  ERR_CODE_O
);

  // Inter-byte gap limit in clock cycles (one byte time = 10 bit times).
  localparam int unsigned LIMIT = TIMEOUT_BYTES * 10 * (CLK_RATE / BAUD_RATE);
  localparam int          TW    = $clog2(LIMIT) + 1;
  localparam logic [TW-1:0] LIMIT_W = TW'(LIMIT);

  localparam logic [7:0] CMD_RD = 8'h01;
  localparam logic [7:0] CMD_WR = 8'h02;

  typedef enum logic [2:0] {IDLE, GET_CMD, GET_ADDR, GET_DATA, HOLD} state_e;

  state_e        state_q, state_d;
  logic          wr_q, wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic busy;
  assign busy = (state_q == GET_CMD) || (state_q == GET_ADDR) || (state_q == GET_DATA);

  // State register and datapath registers; reset drops any partial/held frame silently.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 32'h0;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic: byte sequencing, gap timeout, overrun detection.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = busy ? cnt_q + 1'b1 : cnt_q;
    err_d   = 1'b0;
    code_d  = code_q;

    unique case (state_q)
      IDLE: begin
        if (RX_DONE_I && RX_DATA_I == HEADER) begin
          state_d = GET_CMD;
          cnt_d   = '0;
        end
      end
      GET_CMD: begin
        if (RX_DONE_I) begin
          cnt_d = '0;
          if (RX_DATA_I == CMD_RD || RX_DATA_I == CMD_WR) begin
            wr_d    = (RX_DATA_I == CMD_WR);
            state_d = GET_ADDR;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = 2'b01;
          end
        end
      end
      GET_ADDR: begin
        if (RX_DONE_I) begin
          cnt_d   = '0;
          addr_d  = RX_DATA_I;
          data_d  = 32'h0;          // reads report a zero payload
          idx_d   = 2'd0;
          state_d = wr_q ? GET_DATA : HOLD;
        end
      end
      GET_DATA: begin
        if (RX_DONE_I) begin
          cnt_d = '0;
          data_d[{idx_q, 3'b000} +: 8] = RX_DATA_I;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = HOLD;
        end
      end
      HOLD: begin
        if (CMD_READY_I) begin
          // A byte on the handshake edge is treated as if already idle.
          state_d = IDLE;
          if (RX_DONE_I && RX_DATA_I == HEADER) begin
            state_d = GET_CMD;
            cnt_d   = '0;
          end
        end else if (RX_DONE_I) begin
          err_d  = 1'b1;
          code_d = 2'b11;
        end
      end
      default: state_d = IDLE;
    endcase

    // Gap timeout; a byte landing on the same edge takes priority.
    if (busy && !RX_DONE_I && cnt_q == LIMIT_W) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
      code_d  = 2'b10;
    end
  end

  assign CMD_VALID_O = (state_q == HOLD);
  assign CMD_WRITE_O = wr_q;
  assign CMD_ADDR_O  = addr_q;
  assign CMD_DATA_O  = data_q;
  assign ERR_O       = err_q;
  assign ERR_CODE_O  = code_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed frames plus random frame streams,
// checked every cycle against a frame-level reference model.
module tb_uart_cmd_decoder;

  localparam int unsigned CLK_RATE = 1000;
  localparam int unsigned BAUD     = 100;
  localparam int unsigned TOB      = 4;
  localparam int          LIMIT    = TOB * 10 * (CLK_RATE / BAUD);   // 400 cycles
  localparam logic [7:0]  HDR      = 8'h01;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        RX_DONE_I = 1'b0;
  logic [7:0]  RX_DATA_I = 8'h00;
  logic        CMD_READY_I = 1'b0;
  logic        CMD_VALID_O, CMD_WRITE_O, ERR_O;
  logic [7:0]  CMD_ADDR_O;
  logic [31:0] CMD_DATA_O;
  logic [1:0]  ERR_CODE_O;

  uart_cmd_decoder #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .TIMEOUT_BYTES(TOB), .HEADER(HDR)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .RX_DONE_I(RX_DONE_I), .RX_DATA_I(RX_DATA_I),
    .CMD_VALID_O(CMD_VALID_O), .CMD_READY_I(CMD_READY_I), .CMD_WRITE_O(CMD_WRITE_O),
    .CMD_ADDR_O(CMD_ADDR_O), .CMD_DATA_O(CMD_DATA_O), .ERR_O(ERR_O), .ERR_CODE_O(ERR_CODE_O)
  );

  always #5 CLK_I = ~CLK_I;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: bytes of the frame in progress, plus the held command.
  logic [7:0]  q[$];
  logic        m_held = 1'b0;
  logic        m_wr = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [31:0] m_data = 32'h0;
  logic        m_err = 1'b0;
  logic [1:0]  m_code = 2'b00;
  int          cyc = 0;
  int          last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task model_step(input logic rst, input logic rx, input logic [7:0] b, input logic rdy);
    m_err = 1'b0;
    if (rst) begin
      q.delete(); m_held = 1'b0; m_code = 2'b00;
    end else if (m_held) begin
      if (rdy) begin
        m_held = 1'b0;
        if (rx && b == HDR) begin q.delete(); q.push_back(b); last = cyc; end
      end else if (rx) begin
        m_err = 1'b1; m_code = 2'b11;
      end
    end else if (q.size() == 0) begin
      if (rx && b == HDR) begin q.push_back(b); last = cyc; end
    end else if (rx) begin
      q.push_back(b); last = cyc;
      if (q.size() == 2 && b != 8'h01 && b != 8'h02) begin
        m_err = 1'b1; m_code = 2'b01; q.delete();
      end else if ((q.size() == 3 && q[1] == 8'h01) || (q.size() == 7 && q[1] == 8'h02)) begin
        m_held = 1'b1;
        m_wr   = (q[1] == 8'h02);
        m_addr = q[2];
        m_data = m_wr ? {q[6], q[5], q[4], q[3]} : 32'h0;
        q.delete();
      end
    end else if (cyc - last == LIMIT + 1) begin
      m_err = 1'b1; m_code = 2'b10; q.delete();
    end
  endtask

  task automatic tick(input logic rst, input logic rx, input logic [7:0] b, input logic rdy);
    @(negedge CLK_I);
    RST_I = rst; RX_DONE_I = rx; RX_DATA_I = b; CMD_READY_I = rdy;
    @(posedge CLK_I);
    cyc++;
    model_step(rst, rx, b, rdy);
    #1;
    chk("valid", CMD_VALID_O, m_held);
    chk("err", ERR_O, m_err);
    chk("code", ERR_CODE_O, m_code);
    if (rst) begin
      chk("rst_write", CMD_WRITE_O, 0);
      chk("rst_addr", CMD_ADDR_O, 0);
      chk("rst_data", CMD_DATA_O, 0);
    end else if (m_held) begin
      chk("write", CMD_WRITE_O, m_wr);
      chk("addr", CMD_ADDR_O, m_addr);
      chk("data", CMD_DATA_O, m_data);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    tick(1'b0, 1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) tick(1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic rsend(input logic [7:0] b);
    send(b, 1'($urandom_range(0, 1)));
    repeat ($urandom_range(0, 49) == 0 ? LIMIT + 2 : $urandom_range(0, 3))
      tick(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    int kind;
    // reset
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    idle(2, 1'b0);

    // read with ready high
    send(8'h01, 1'b1); send(8'h01, 1'b1); send(8'h3C, 1'b1);
    idle(3, 1'b1);

    // write with 20 cycles of backpressure
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h10, 1'b0);
    send(8'hEF, 1'b0); send(8'hBE, 1'b0); send(8'hAD, 1'b0); send(8'hDE, 1'b0);
    idle(20, 1'b0);
    idle(3, 1'b1);

    // junk, bad command, then a good read
    send(8'h55, 1'b1); send(8'hAA, 1'b1); send(8'h01, 1'b1); send(8'h07, 1'b1);
    idle(2, 1'b1);
    send(8'h01, 1'b1); send(8'h01, 1'b1); send(8'h05, 1'b1);
    idle(2, 1'b1);

    // timeout mid write frame, then recovery
    send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h20, 1'b1); send(8'h11, 1'b1);
    idle(LIMIT + 3, 1'b1);
    send(8'h01, 1'b1); send(8'h01, 1'b1); send(8'h42, 1'b1);
    idle(2, 1'b1);

    // byte exactly at the timeout edge wins
    send(8'h01, 1'b1); send(8'h01, 1'b1);
    idle(LIMIT, 1'b1);
    send(8'h99, 1'b1);
    idle(2, 1'b1);

    // overrun while held, then header on the handshake edge
    send(8'h01, 1'b0); send(8'h01, 1'b0); send(8'h77, 1'b0);
    idle(2, 1'b0);
    send(8'h01, 1'b0);
    idle(1, 1'b0);
    send(8'h01, 1'b1);
    send(8'h01, 1'b1); send(8'h09, 1'b1);
    idle(2, 1'b1);

    // reset mid payload, then fresh write with header value inside payload
    send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h30, 1'b1); send(8'hAA, 1'b1); send(8'hBB, 1'b1);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h31, 1'b1);
    send(8'h01, 1'b1); send(8'h23, 1'b1); send(8'h45, 1'b1); send(8'h67, 1'b1);
    idle(3, 1'b1);

    // random frame stream with random ready
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        rsend(8'($urandom));
      end else if (kind == 1) begin
        rsend(HDR); rsend(8'($urandom_range(3, 255)));
      end else if (kind < 6) begin
        rsend(HDR); rsend(8'h01); rsend(8'($urandom));
      end else begin
        rsend(HDR); rsend(8'h02); rsend(8'($urandom));
        for (int k = 0; k < 4; k++) rsend(8'($urandom));
      end
    end
    idle(5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
